// File: rtl/fcs_strip.sv
// fcs_strip: withholds the trailing 32-bit FCS of an RMII dibit stream.
// Every dibit passes through a FCS_DIBITS-deep delay line, so the last
// FCS_DIBITS dibits of a frame are still buffered when the frame ends and
// are simply dropped. At end of frame the payload byte length and
// runt/misalignment status are reported alongside a one-cycle done pulse.
module fcs_strip #(
  parameter int FCS_DIBITS = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             done,
  output logic [LEN_W-1:0] len,
  output logic             runt,
  output logic             misalign
);

  localparam int FILL_W = $clog2(FCS_DIBITS + 1);
  localparam int CNT_W  = LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Delay line: index 0 holds the newest dibit, FCS_DIBITS-1 the oldest.
  logic [FCS_DIBITS-1:0][1:0] dl_q, dl_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  state_t                     state_q, state_d;

  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             runt_q, runt_d;
  logic             mis_q, mis_d;

  // Payload dibit counter sticks at all-ones instead of wrapping, which
  // also pins the reported byte length at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic [FCS_DIBITS-1:0][1:0] shift_in(
    input logic [FCS_DIBITS-1:0][1:0] line,
    input logic [1:0]                 d
  );
    return {line[FCS_DIBITS-2:0], d};
  endfunction

  // Next-state, delay-line update and registered-output computation.
  always_comb begin
    state_d = state_q;
    dl_d    = dl_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    axiov_d = 1'b0;
    axiod_d = 2'b00;
    done_d  = 1'b0;
    len_d   = len_q;
    runt_d  = runt_q;
    mis_d   = mis_q;

    case (state_q)
      IDLE: begin
        if (axiiv) begin
          dl_d    = shift_in(dl_q, axiid);
          fill_d  = FILL_W'(1);
          state_d = FILL;
        end
      end

      FILL, STREAM: begin
        if (axiiv) begin
          if (state_q == STREAM || fill_q == FILL_W'(FCS_DIBITS)) begin
            // Line is full: the oldest dibit is provably payload.
            axiov_d = 1'b1;
            axiod_d = dl_q[FCS_DIBITS-1];
            cnt_d   = sat_inc(cnt_q);
            state_d = STREAM;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
          dl_d = shift_in(dl_q, axiid);
        end else begin
          // End of frame: report, then drop the buffered FCS.
          done_d  = 1'b1;
          len_d   = cnt_q[CNT_W-1:2];
          runt_d  = (cnt_q == '0);
          mis_d   = (cnt_q[1:0] != 2'b00);
          dl_d    = '0;
          fill_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        dl_d    = '0;
        fill_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, delay line and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dl_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
      done_q  <= 1'b0;
      len_q   <= '0;
      runt_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      done_q  <= done_d;
      len_q   <= len_d;
      runt_q  <= runt_d;
      mis_q   <= mis_d;
    end
  end

  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign done     = done_q;
  assign len      = len_q;
  assign runt     = runt_q;
  assign misalign = mis_q;

endmodule
